// File: rtl/window_scan_counter_if.sv
// Handshake/bus bundle for window_scan_counter.
// master: the scan counter itself (drives coordinates and status).
// slave:  the controller/consumer (drives start, limits, enable).
// Stride signals exist only when SCAN_STEP_EN is defined.
interface window_scan_counter_if #(
    parameter int DATA_WIDTH = 12
);
    logic                  start;
    logic                  enable;
    logic                  continuous;
    logic [DATA_WIDTH-1:0] max_x;
    logic [DATA_WIDTH-1:0] max_y;
`ifdef SCAN_STEP_EN
    logic [DATA_WIDTH-1:0] step_x;
    logic [DATA_WIDTH-1:0] step_y;
`endif
    logic [DATA_WIDTH-1:0] ctr_x;
    logic [DATA_WIDTH-1:0] ctr_y;
    logic                  valid;
    logic                  busy;
    logic                  end_row;
    logic                  end_count;

    modport master (
`ifdef SCAN_STEP_EN
        input  step_x, step_y,
`endif
        input  start, enable, continuous, max_x, max_y,
        output ctr_x, ctr_y, valid, busy, end_row, end_count
    );

    modport slave (
`ifdef SCAN_STEP_EN
        output step_x, step_y,
`endif
        output start, enable, continuous, max_x, max_y,
        input  ctr_x, ctr_y, valid, busy, end_row, end_count
    );
endinterface

// File: rtl/window_scan_counter.sv
// window_scan_counter: 2-D (x, y) window-origin scan counter.
// Steps x across a row, wraps to the next y, pulses end_row on every x wrap
// and end_count when the last position of the frame is consumed.
// Optional macro SCAN_STEP_EN: run-time strides step_x/step_y latched at
// start (0 treated as 1). Without it both strides are fixed at 1.
module window_scan_counter #(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    window_scan_counter_if.master bus
);
    localparam int W = DATA_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    logic [W-1:0]   x_q, y_q;
    logic [W-1:0]   lim_x, lim_y;
    logic           cont_q;
    logic           valid_q, busy_q, end_row_q, end_count_q;
    logic [W-1:0]   stp_x, stp_y;
    logic [W:0]     sum_x, sum_y;
    logic           adv;

`ifdef SCAN_STEP_EN
    // A zero stride would stall the scan forever; treat it as 1.
    function automatic logic [W-1:0] nz_step(input logic [W-1:0] s);
        return (s == '0) ? W'(1) : s;
    endfunction
`else
    assign stp_x = W'(1);
    assign stp_y = W'(1);
`endif

    // One extra bit so a sum past the limit never aliases back into range.
    assign sum_x = {1'b0, x_q} + {1'b0, stp_x};
    assign sum_y = {1'b0, y_q} + {1'b0, stp_y};
    assign adv   = valid_q & bus.enable;

    // Scan FSM with registered coordinates, status and one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            lim_x       <= '0;
            lim_y       <= '0;
            cont_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            end_row_q   <= 1'b0;
            end_count_q <= 1'b0;
`ifdef SCAN_STEP_EN
            stp_x       <= '0;
            stp_y       <= '0;
`endif
        end else begin
            end_row_q   <= 1'b0;
            end_count_q <= 1'b0;
            case (state)
                IDLE: begin
                    // The end_count cycle of a one-shot scan is not yet a
                    // free IDLE cycle; a new start is taken from the next one.
                    if (bus.start && !end_count_q) begin
                        lim_x   <= bus.max_x;
                        lim_y   <= bus.max_y;
                        cont_q  <= bus.continuous;
`ifdef SCAN_STEP_EN
                        stp_x   <= nz_step(bus.step_x);
                        stp_y   <= nz_step(bus.step_y);
`endif
                        x_q     <= '0;
                        y_q     <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        if (sum_x <= {1'b0, lim_x}) begin
                            x_q <= sum_x[W-1:0];
                        end else begin
                            x_q       <= '0;
                            end_row_q <= 1'b1;
                            if (sum_y <= {1'b0, lim_y}) begin
                                y_q <= sum_y[W-1:0];
                            end else begin
                                y_q         <= '0;
                                end_count_q <= 1'b1;
                                if (!cont_q) begin
                                    valid_q <= 1'b0;
                                    busy_q  <= 1'b0;
                                    state   <= IDLE;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ctr_x     = x_q;
    assign bus.ctr_y     = y_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.end_row   = end_row_q;
    assign bus.end_count = end_count_q;
endmodule

// File: tb/tb_window_scan_counter.sv
// Randomized scoreboard bench for window_scan_counter (DATA_WIDTH=4 so the
// top-of-range limit 15 is reachable). The reference frame is built with
// nested loops over the visited coordinates; a monitor pops one expected
// position per consumed DUT position and checks the following-cycle pulses.
module tb_window_scan_counter;
    localparam int DW = 4;

    typedef struct {
        int x;
        int y;
        bit er;
        bit ec;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    bit   pend_er = 0, pend_ec = 0, pend_idle = 0;

    window_scan_counter_if #(.DATA_WIDTH(DW)) sif ();

    window_scan_counter #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compares whatever the DUT presents against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            pend_er   = 0;
            pend_ec   = 0;
            pend_idle = 0;
        end else begin
            chk("end_row", int'(sif.end_row), int'(pend_er));
            chk("end_count", int'(sif.end_count), int'(pend_ec));
            if (pend_idle) begin
                chk("valid_drop", int'(sif.valid), 0);
                chk("busy_drop", int'(sif.busy), 0);
            end
            pend_er   = 0;
            pend_ec   = 0;
            pend_idle = 0;
            if (sif.valid && q.size() > 0) begin
                chk("ctr_x", int'(sif.ctr_x), q[0].x);
                chk("ctr_y", int'(sif.ctr_y), q[0].y);
                chk("busy_run", int'(sif.busy), 1);
                if (sif.enable) begin
                    exp_t e;
                    e = q.pop_front();
                    pend_er   = e.er;
                    pend_ec   = e.ec;
                    pend_idle = e.last;
                end
            end else if (sif.valid && sif.enable) begin
                chk("unexpected_advance", 1, 0);
            end
        end
    end

    // Reference frame: every visited origin in raster order.
    task automatic push_frame(input int mx, my, sx, sy, input bit cont);
        int ex, ey;
`ifdef SCAN_STEP_EN
        ex = (sx == 0) ? 1 : sx;
        ey = (sy == 0) ? 1 : sy;
`else
        ex = 1;
        ey = 1;
`endif
        for (int y = 0; y <= my; y += ey) begin
            for (int x = 0; x <= mx; x += ex) begin
                exp_t e;
                e.x    = x;
                e.y    = y;
                e.er   = (x + ex > mx);
                e.ec   = e.er && (y + ey > my);
                e.last = e.ec && !cont;
                q.push_back(e);
            end
        end
    endtask

    task automatic drive_cfg(input int mx, my, sx, sy);
        sif.max_x = DW'(mx);
        sif.max_y = DW'(my);
`ifdef SCAN_STEP_EN
        sif.step_x = DW'(sx);
        sif.step_y = DW'(sy);
`endif
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctr_x"}, int'(sif.ctr_x), 0);
        chk({tag, "_ctr_y"}, int'(sif.ctr_y), 0);
        chk({tag, "_valid"}, int'(sif.valid), 0);
        chk({tag, "_busy"}, int'(sif.busy), 0);
        chk({tag, "_end_row"}, int'(sif.end_row), 0);
        chk({tag, "_end_count"}, int'(sif.end_count), 0);
    endtask

    // Reset pulse applied from posedge+1; outputs checked while still in reset.
    task automatic do_reset(input string tag);
        sif.enable = 1'b0;
        sif.start  = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        check_zero(tag);
        #1 reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // One scan: en_pct<0 selects the fixed 1,0,0,1 enable pattern.
    task automatic scan(input int mx, my, sx, sy, input bit cont,
                        input int frames, input int en_pct, input bit mid_start);
        int  g;
        bit [3:0] pat;
        pat = 4'b1001;
        @(posedge clk); #1;
        drive_cfg(mx, my, sx, sy);
        sif.continuous = cont;
        sif.start      = 1'b1;
        for (int f = 0; f < frames; f++) push_frame(mx, my, sx, sy, cont);
        @(posedge clk); #1;
        sif.start = 1'b0;
        g = 0;
        while (q.size() > 0 && g < 3000) begin
            // Config inputs and stray starts must be ignored during RUN.
            drive_cfg($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
            sif.continuous = $urandom_range(1);
            sif.start = mid_start && ($urandom_range(3) == 0);
            if (en_pct < 0) sif.enable = pat[g % 4];
            else            sif.enable = ($urandom_range(99) < en_pct);
            @(posedge clk); #1;
            g++;
        end
        sif.enable = 1'b0;
        sif.start  = 1'b0;
        chk("scan_drained", q.size(), 0);
        @(posedge clk); #1;
        if (cont || q.size() > 0) do_reset("stop");
    endtask

    initial begin
        int g;
        reset          = 1'b1;
        sif.start      = 1'b0;
        sif.enable     = 1'b0;
        sif.continuous = 1'b0;
        drive_cfg(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        #1 reset = 1'b0;

        // Basic raster, one-shot, enable held high.
        scan(3, 2, 1, 1, 1'b0, 1, 100, 1'b0);
`ifdef SCAN_STEP_EN
        scan(5, 0, 2, 1, 1'b0, 1, 100, 1'b0);
        scan(2, 0, 0, 1, 1'b0, 1, 100, 1'b0);
        scan(15, 15, 3, 5, 1'b0, 1, 100, 1'b0);
`else
        scan(15, 15, 1, 1, 1'b0, 1, 100, 1'b0);
`endif
        // Continuous: three frames back to back, then stopped by reset.
        scan(1, 1, 1, 1, 1'b1, 3, 100, 1'b0);
        // Stalls plus ignored mid-run start pulses.
        scan(3, 2, 1, 1, 1'b0, 1, -1, 1'b1);

        // Reset mid-scan at (2,1), then a fresh scan from (0,0).
        @(posedge clk); #1;
        drive_cfg(3, 2, 1, 1);
        sif.continuous = 1'b0;
        sif.start      = 1'b1;
        push_frame(3, 2, 1, 1, 1'b0);
        @(posedge clk); #1;
        sif.start  = 1'b0;
        sif.enable = 1'b1;
        g = 0;
        while (q.size() > 6 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        sif.enable = 1'b0;
        chk("midreset_reach", q.size(), 6);
        do_reset("midreset");
        scan(1, 0, 1, 1, 1'b0, 1, 100, 1'b0);

        // Randomized scans.
        for (int i = 0; i < 10; i++) begin
            scan($urandom_range(7), $urandom_range(4), $urandom_range(3), $urandom_range(3),
                 (i == 9), (i == 9) ? 2 : 1, $urandom_range(40, 100), $urandom_range(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/window_scan_counter.md
# window_scan_counter

Parametrised 2-D scan counter generating (x, y) window-origin coordinates for the Haar classifier datapath, replacing the single-dimension counter used by the memory address generators. It steps x across a row, wraps to the next y, and flags row and frame completion. It supports run-time limits and strides, one-shot or continuous scanning, and a valid/enable handshake so downstream stages can stall the scan.

## Interface
- DATA_WIDTH, 12, width of each coordinate, limit and step
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  begin a scan; sampled only in IDLE
- enable  in  1  consumer ready; advances position when valid=1
- continuous  in  1  latched at start; 1 = restart at (0,0) after last position
- max_x  in  DATA_WIDTH  inclusive x limit, latched at start
- max_y  in  DATA_WIDTH  inclusive y limit, latched at start
- step_x  in  DATA_WIDTH  x stride, latched at start (only with SCAN_STEP_EN)
- step_y  in  DATA_WIDTH  y stride, latched at start (only with SCAN_STEP_EN)
- ctr_x  out  DATA_WIDTH  current x coordinate
- ctr_y  out  DATA_WIDTH  current y coordinate
- valid  out  1  ctr_x/ctr_y hold a position to be consumed
- busy  out  1  scan in progress (RUN state)
- end_row  out  1  one-cycle pulse, x wrapped
- end_count  out  1  one-cycle pulse, final position of frame consumed

## Operation
- States: IDLE, RUN.
- IDLE: valid=0, busy=0, ctr_x=ctr_y=0. start=1 -> latch max_x, max_y, continuous, steps; enter RUN next cycle.
- RUN: valid=1, busy=1. Advance = valid & enable. No advance -> all outputs hold.
- Advance with ctr_x+step_x <= max_x: ctr_x += step_x.
- Otherwise (x wrap): ctr_x=0, end_row=1 next cycle. Then, if ctr_y+step_y <= max_y: ctr_y += step_y.
- Otherwise (frame end): end_row=1 and end_count=1 next cycle, ctr_y=0. continuous=1 -> stay RUN, valid stays 1 at (0,0). continuous=0 -> IDLE, valid=0 in the same cycle end_count is high.
- Comparisons use DATA_WIDTH+1-bit sums; no coordinate ever wraps modulo 2^DATA_WIDTH.
- Step value 0 is treated as 1.
- Positions visited per row: floor(max_x/step_x)+1; per frame: rows x that.
- start while in RUN is ignored. Limit/step input changes during RUN are ignored.
- reset in any state: IDLE next cycle; all outputs 0; latched config cleared.

## Timing
- Reset values: ctr_x=0, ctr_y=0, valid=0, busy=0, end_row=0, end_count=0.
- start -> first valid position (0,0) one cycle later.
- Each advance updates coordinates on the following edge; throughput one position per cycle with enable held high.
- end_row/end_count are registered and high for exactly one cycle, aligned with the updated coordinates.
- One-shot: start accepted again in the cycle after end_count (first IDLE cycle).
- reset has priority over start and enable in the same cycle.

## Configuration
- SCAN_STEP_EN defined: step_x/step_y ports present; strides latched at start as above.
- SCAN_STEP_EN undefined: step_x/step_y ports absent; both strides fixed at 1; the adders reduce to incrementers; all other behaviour identical.

## Test plan
- max_x=3, max_y=2, step 1/1, enable=1, one-shot -> 12 positions raster order (0,0)..(3,2); end_row after advances 4, 8, 12; end_count once after 12th; valid=0 next cycle.
- SCAN_STEP_EN, max_x=5, step_x=2, max_y=0 -> x sequence 0,2,4 then end_row+end_count; step_x=0 with max_x=2 -> 0,1,2.
- DATA_WIDTH=4, max_x=15, step_x=3, max_y=15, step_y=5 -> x 0,3,..,15 and y 0,5,10,15; no overflow past 15; 24 positions total.
- continuous=1, max_x=1, max_y=1 -> end_count every 4 advances, valid never drops, coordinates return to (0,0).
- enable toggled 1,0,0,1 -> coordinates hold during the low cycles; no extra end_row; start pulsed mid-run has no effect.
- reset asserted at (2,1) mid-scan -> next cycle all outputs 0, state IDLE; a new start then begins at (0,0).
